// File: rtl/control_seq.sv
// control_seq: issues N_CMD one-hot command strobes in order, each waiting for ready_command
// with a per-attempt timeout and bounded retry. Define CONTROL_SEQ_LOOP_EN for free-running mode.
module control_seq #(
  parameter int unsigned N_CMD     = 4,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned TMR_W     = 16,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned IdxW     = $clog2(N_CMD)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_ready_command,
  output logic [N_CMD-1:0] o_command,
  output logic [IdxW-1:0]  o_cmd_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [3:0]       o_retry_cnt
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StDone, StError} state_e;

  localparam logic [TMR_W-1:0] TmrLast  = TMR_W'(TIMEOUT - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_CMD - 1);
  localparam logic [3:0]       RetryMax = 4'(MAX_RETRY);

  state_e            r_state, w_state_d;
  logic [TMR_W-1:0]  r_timer, w_timer_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic [3:0]        r_retry, w_retry_d;
  logic [N_CMD-1:0]  r_command;
  logic              r_busy, r_done, r_error;
  logic              w_busy_d;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_retry_d = r_retry;
    w_timer_d = r_timer;
    case (r_state)
      StIdle, StError: begin
        if (i_start) begin
          w_state_d = StIssue;
          w_idx_d   = '0;
          w_retry_d = '0;
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        // An ack in the final timer cycle still counts as an ack.
        if (i_ready_command) begin
          w_state_d = StNext;
        end else if (r_timer == TmrLast) begin
          if (r_retry < RetryMax) begin
            w_retry_d = r_retry + 4'd1;
            w_state_d = StIssue;
          end else begin
            w_state_d = StError;
          end
        end
      end
      StNext: begin
        if (r_idx == IdxLast) begin
          w_state_d = StDone;
        end else begin
          w_idx_d   = r_idx + IdxW'(1);
          w_retry_d = '0;
          w_state_d = StIssue;
        end
      end
      StDone: begin
`ifdef CONTROL_SEQ_LOOP_EN
        w_state_d = StIssue;
        w_idx_d   = '0;
        w_retry_d = '0;
`else
        w_state_d = StIdle;
`endif
      end
      default: w_state_d = StIdle;
    endcase

    // The ISSUE cycle is timer count 0, so one attempt spans exactly TIMEOUT cycles.
    if (w_state_d == StIssue) begin
      w_timer_d = '0;
    end else if ((r_state == StIssue || r_state == StWait) && r_timer != TmrLast) begin
      w_timer_d = r_timer + TMR_W'(1);
    end
  end

  assign w_busy_d = (w_state_d == StIssue) || (w_state_d == StWait) ||
                    (w_state_d == StNext)  || (w_state_d == StDone);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_idx     <= '0;
      r_retry   <= '0;
      r_command <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_timer   <= w_timer_d;
      r_idx     <= w_idx_d;
      r_retry   <= w_retry_d;
      // Strobe appears the cycle after ISSUE, while WAIT is already listening for the ack.
      r_command <= (r_state == StIssue) ? (N_CMD'(1) << r_idx) : '0;
      r_busy    <= w_busy_d;
      r_done    <= (w_state_d == StDone);
      r_error   <= (w_state_d == StError);
    end
  end

  assign o_command   = r_command;
  assign o_cmd_idx   = r_idx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: a timeline model turns each directed scenario into per-cycle expected
// outputs; a negedge process compares every cycle, and literal checks pin the model's timing.
module tb_control_seq;

  localparam int N    = 4;
  localparam int T    = 8;
  localparam int MR   = 3;
  localparam int MAXC = 700;

  localparam int HBusy  = 0;
  localparam int HErr   = 1;
  localparam int HIdx   = 2;
  localparam int HRetry = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         rdy   = 1'b0;
  logic [N-1:0] cmd;
  logic [1:0]   idx;
  logic         busy, done, err;
  logic [3:0]   rcnt;

  control_seq #(
    .N_CMD    (N),
    .TIMEOUT  (T),
    .TMR_W    (8),
    .MAX_RETRY(MR)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_start        (start),
    .i_ready_command(rdy),
    .o_command      (cmd),
    .o_cmd_idx      (idx),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (err),
    .o_retry_cnt    (rcnt)
  );

  always #5 clk = ~clk;

  // Index c means "the value present after rising edge c".
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_cmd [MAXC];
  int exp_busy[MAXC];
  int exp_done[MAXC];
  int exp_err [MAXC];
  int exp_idx [MAXC];
  int exp_rcnt[MAXC];
  int act_cmd [MAXC];
  int act_busy[MAXC];
  int act_done[MAXC];
  int act_err [MAXC];
  int act_idx [MAXC];
  int act_rcnt[MAXC];
  bit start_plan[MAXC];
  bit rdy_plan  [MAXC];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cyc < MAXC) begin
      start = start_plan[cyc];
      rdy   = rdy_plan[cyc];
    end
  end

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      act_cmd[cyc]  = int'(cmd);
      act_busy[cyc] = int'(busy);
      act_done[cyc] = int'(done);
      act_err[cyc]  = int'(err);
      act_idx[cyc]  = int'(idx);
      act_rcnt[cyc] = int'(rcnt);
      chk("command",   32'(cmd),  32'(exp_cmd[cyc]));
      chk("busy",      32'(busy), 32'(exp_busy[cyc]));
      chk("done",      32'(done), 32'(exp_done[cyc]));
      chk("error",     32'(err),  32'(exp_err[cyc]));
      chk("cmd_idx",   32'(idx),  32'(exp_idx[cyc]));
      chk("retry_cnt", 32'(rcnt), 32'(exp_rcnt[cyc]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input int c, input int which, input int v);
    for (int k = c; k < MAXC; k++) begin
      case (which)
        HBusy:   exp_busy[k] = v;
        HErr:    exp_err[k]  = v;
        HIdx:    exp_idx[k]  = v;
        default: exp_rcnt[k] = v;
      endcase
    end
  endtask

  task automatic clear_from(input int c);
    for (int k = c; k < MAXC; k++) begin
      exp_cmd[k] = 0; exp_busy[k] = 0; exp_done[k] = 0;
      exp_err[k] = 0; exp_idx[k]  = 0; exp_rcnt[k] = 0;
      start_plan[k] = 1'b0; rdy_plan[k] = 1'b0;
    end
  endtask

  // Timeline model: an attempt issued at edge e strobes at e+1; a timeout re-issues at e+T;
  // an ack seen w cycles after ISSUE moves on at e+w+2 (that edge is DONE after the last one).
  task automatic plan_seq(input int s, input int nto[N], input int w[N], input bit rdy_issue,
                          input int passes, output int fin);
    int e;
    start_plan[s-1] = 1'b1;
    hold(s, HBusy, 1); hold(s, HErr, 0); hold(s, HIdx, 0); hold(s, HRetry, 0);
    e   = s;
    fin = s;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < N; i++) begin
        for (int a = 0; a <= nto[i]; a++) begin
          exp_cmd[e+1] = 1 << i;
          if (rdy_issue) rdy_plan[e] = 1'b1;
          if (a < nto[i]) begin
            if (a == MR) begin
              hold(e + T, HErr, 1);
              hold(e + T, HBusy, 0);
              fin = e + T;
              return;
            end
            e += T;
            hold(e, HRetry, a + 1);
          end else begin
            rdy_plan[e + w[i]] = 1'b1;
            e += w[i] + 2;
            if (i < N - 1) begin
              hold(e, HIdx, i + 1);
              hold(e, HRetry, 0);
            end
          end
        end
      end
      exp_done[e] = 1;
      fin = e + 1;
`ifdef CONTROL_SEQ_LOOP_EN
      e = e + 1;
      hold(e, HIdx, 0);
      hold(e, HRetry, 0);
`else
      hold(e + 1, HBusy, 0);
`endif
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
    #2;
  endtask

  function automatic int find_done(input int from, input int to);
    for (int k = from; k <= to; k++) if (act_done[k] != 0) return k;
    return -1;
  endfunction

  function automatic int count_cmd(input int from, input int to, input int v);
    int n = 0;
    for (int k = from; k <= to; k++) if (act_cmd[k] == v) n++;
    return n;
  endfunction

  task automatic reset_pulse(input int c);
    clear_from(c);
    rst_n = 1'b0;
    #1;
    chk("rst_command", 32'(cmd),  32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_error",   32'(err),  32'd0);
    chk("rst_cmd_idx", 32'(idx),  32'd0);
    chk("rst_retry",   32'(rcnt), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int s, s2, fin, d1, d2, nz;
    int nto[N];
    int w[N];

    repeat (10) @(negedge clk);
    #2 rst_n = 1'b1;
    s = cyc;
    wait_to(s + 100);
    chk("idle_quiet", 32'(count_cmd(s, s + 100, 0)), 32'd101);

`ifdef CONTROL_SEQ_LOOP_EN
    s = cyc + 3; nto = '{0, 0, 0, 0}; w = '{1, 1, 1, 1};
    plan_seq(s, nto, w, 1'b0, 3, fin);
    wait_to(fin - 1);
    d1 = find_done(s, fin);
    d2 = find_done(d1 + 1, fin);
    chk("loop_first_done", 32'(d1 - s), 32'd12);
    chk("loop_done_gap",   32'(d2 - d1), 32'd13);
    nz = 0;
    for (int k = s; k < fin; k++) if (act_busy[k] == 0) nz++;
    chk("loop_busy_held", 32'(nz), 32'd0);
    reset_pulse(fin);
`else
    // Normal pass, ack one cycle after each strobe, with a stray start while busy.
    s = cyc + 3; nto = '{0, 0, 0, 0}; w = '{2, 2, 2, 2};
    plan_seq(s, nto, w, 1'b0, 1, fin);
    start_plan[s+5] = 1'b1;
    wait_to(fin + 3);
    for (int i = 0; i < N; i++) chk("norm_pulse", 32'(act_cmd[s + 1 + 4*i]), 32'(1 << i));
    chk("norm_done_at", 32'(find_done(s, fin + 3) - s), 32'd16);
    chk("norm_busy_after", 32'(act_busy[fin + 2]), 32'd0);

    // One timeout on command 0, then acks.
    s = cyc + 3; nto = '{1, 0, 0, 0}; w = '{2, 1, 1, 1};
    plan_seq(s, nto, w, 1'b0, 1, fin);
    wait_to(fin + 3);
    chk("retry_pulses", 32'(count_cmd(s, fin, 1)), 32'd2);
    chk("retry_gap_1",  32'(act_cmd[s + 9]), 32'd1);
    chk("retry_cnt_1",  32'(act_rcnt[s + 9]), 32'd1);

    // Exhaustion, then a fresh start from ERROR with immediate acks.
    s = cyc + 3; nto = '{4, 0, 0, 0}; w = '{1, 1, 1, 1};
    plan_seq(s, nto, w, 1'b0, 1, fin);
    wait_to(fin + 5);
    chk("exh_pulses",  32'(count_cmd(s, fin + 5, 1)), 32'd4);
    chk("exh_err_at",  32'(fin - s), 32'd32);
    chk("exh_error",   32'(act_err[fin + 5]), 32'd1);
    chk("exh_busy",    32'(act_busy[fin + 5]), 32'd0);
    s2 = cyc + 3; nto = '{0, 0, 0, 0};
    plan_seq(s2, nto, w, 1'b0, 1, fin);
    wait_to(fin + 3);
    chk("restart_err_clr", 32'(act_err[s2]), 32'd0);
    chk("restart_pulse",   32'(act_cmd[s2 + 1]), 32'd1);
    chk("min_latency",     32'(find_done(s2, fin) - (s2 - 1) + 1), 32'd14);

    // Ack on the last timer cycle; ready also high in every ISSUE cycle.
    s = cyc + 3; nto = '{0, 0, 0, 0}; w = '{T - 1, 1, 1, 1};
    plan_seq(s, nto, w, 1'b1, 1, fin);
    wait_to(fin + 3);
    chk("bound_done_at", 32'(find_done(s, fin) - s), 32'd18);
    nz = 0;
    for (int k = s; k <= fin; k++) if (act_rcnt[k] != 0) nz++;
    chk("bound_no_retry", 32'(nz), 32'd0);

    // Asynchronous reset while waiting on command 2.
    s = cyc + 3; nto = '{0, 0, 0, 0}; w = '{3, 3, 3, 3};
    plan_seq(s, nto, w, 1'b0, 1, fin);
    wait_to(s + 12);
    chk("pre_rst_idx", 32'(idx), 32'd2);
    reset_pulse(s + 13);
    wait_to(cyc + 20);
    chk("post_rst_quiet", 32'(count_cmd(s + 13, cyc, 0)), 32'(cyc - s - 12));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
